cpu_trace_buffer: RTL and testbench
===================================

# cpu_trace_buffer

Hardware trace capture stage sitting directly downstream of `sccomp_dataflow`. It snoops each retired instruction's `pc`, `inst` and register-file write, and buffers records in an on-chip FIFO. It drains them as a 32-bit word stream with a valid/ready handshake, for a UART/JTAG dumper on FPGA. It replaces the per-cycle simulation file dump with a synthesizable equivalent whose word order matches it.

## Interface
- `DEPTH`, 16: FIFO depth in records; power of two, ≥2.
- `DROP_W`, 16: width of dropped-record counter.

- `clk_in`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low (0 = reset, sampled on `clk_in` rising edge).
- `cap_valid`  in  1  one instruction retires this cycle; capture fields below.
- `pc`  in  32  PC of retiring instruction.
- `inst`  in  32  instruction word.
- `rf_we`  in  1  retiring instruction writes the register file.
- `rf_waddr`  in  5  destination register.
- `rf_wdata`  in  32  write data.
- `clr_stat`  in  1  pulse: clear `overflow` and `drop_cnt`.
- `out_valid`  out  1  `out_data` holds a valid stream word.
- `out_ready`  in  1  consumer accepts word when high with `out_valid`.
- `out_data`  out  32  stream word.
- `out_last`  out  1  high on the final word of a record.
- `overflow`  out  1  sticky: at least one record dropped.
- `drop_cnt`  out  DROP_W  saturating count of dropped records.
- `level`  out  $clog2(DEPTH)+1  records currently stored.

## Operation
- Record is 102 bits: {pc, inst, rf_we, rf_waddr, rf_wdata}.
- Stream word order per record:
  - W0 = pc.
  - W1 = inst.
  - W2 = {rf_we, 26'b0, rf_waddr}.
  - W3 = rf_wdata, with `out_last`=1.
- When `rf_we`=0, W2 and W3 still carry the captured `rf_waddr`/`rf_wdata` unmodified.
- Push: `cap_valid`=1 and `level`<DEPTH → record written at the tail.
- Full: `cap_valid`=1 and `level`==DEPTH → record dropped.
  - The drop happens even if a pop occurs in the same cycle; fullness is judged on the pre-edge `level`.
  - On a drop, `overflow`←1 and `drop_cnt`←`drop_cnt`+1, saturating at all-ones.
- Serializer state `widx` ∈ {W0,W1,W2,W3}.
  - `out_valid` = (`level`≠0).
  - `out_data` is a combinational mux of the FIFO head by `widx`.
  - On handshake (`out_valid`&`out_ready`): W0→W1→W2→W3. At W3 the head is popped and `widx`→W0.
  - With no handshake, `widx` and `out_data` hold, so the AXI-stream-style stability rule is met.
- Simultaneous push and W3 pop when not full: `level` unchanged; both take effect.
- `clr_stat` has priority over a same-cycle drop increment. Result: `overflow`=0, `drop_cnt`=0.
- Pointers wrap modulo DEPTH. `level` distinguishes full from empty.
- Reset (`reset`=0 at an edge):
  - Pointers, `level`, `widx`=W0, `overflow`=0 and `drop_cnt`=0, so `out_valid`=0.
  - A partially streamed record is discarded.
  - FIFO storage is not cleared.
  - `cap_valid` is ignored while `reset`=0.

## Timing
- Capture-to-output latency: a record pushed at edge N drives `out_valid`=1 with W0 after edge N (visible in cycle N+1).
- Stream throughput: 1 word/cycle with `out_ready` held high, i.e. 4 cycles/record.
  - The CPU retires 1 record/cycle, so sustained capture overflows after DEPTH + ⌊DEPTH/3⌋ records.
- `overflow`, `drop_cnt` and `level` update at the edge of the triggering event. All outputs are registered or a mux of registered state; there is no combinational path from `cap_valid` to any output.
- The path from `out_ready` to FIFO pointers is sequential only.

## Structure
- Package `cpu_trace_pkg`:
  - `TRACE_REC_W`=102.
  - Field offset constants.
  - `widx` enum (W0..W3).
  - W2 packing function.
- Sub-module `trace_fifo`: synchronous single-clock FIFO.
  - Parameters: width, depth.
  - Ports: push/pop/full/empty/level, same reset.
- `cpu_trace_buffer` holds the drop/overflow logic and the serializer.

## Test plan
- Reset, then push one record:
  - Stimulus: pc=0x00400000, inst=0x3C010000, rf_we=1, waddr=1, wdata=0.
  - Hold `out_ready`=1.
  - Response: words 00400000, 3C010000, 80000001, 00000000 on consecutive cycles; `out_last` only on the 4th word; then `out_valid`=0.
- Backpressure:
  - Stimulus: `out_ready`=0 for 5 cycles during W1.
  - Response: `out_data` stays 3C010000 and `widx` holds; resumes correctly when `out_ready`=1.
- Overflow (DEPTH=16):
  - Stimulus: `out_ready`=0; push 20 records.
  - Response: `level`=16, `drop_cnt`=4, `overflow`=1; the stream drains the first 16 records in push order.
- Push on the full edge with a W3 pop in the same cycle:
  - Response: record dropped, `drop_cnt` increments, `level` 16→15.
- Clear priority:
  - Stimulus: `clr_stat` coincides with a drop.
  - Response: `drop_cnt`=0, `overflow`=0.
- Mid-stream reset:
  - Stimulus: `reset`=0 for 1 cycle during W2 of record 3.
  - Response: `out_valid`=0 and `level`=0 next cycle. The next capture streams from W0.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// Shared constants, serializer word index and W2 packing for the CPU trace buffer.
package cpu_trace_pkg;
  localparam int unsigned TRACE_REC_W = 102;

  // Record layout: {pc, inst, rf_we, rf_waddr, rf_wdata}
  localparam int unsigned PC_LSB    = 70;
  localparam int unsigned INST_LSB  = 38;
  localparam int unsigned WE_BIT    = 37;
  localparam int unsigned WADDR_LSB = 32;
  localparam int unsigned WDATA_LSB = 0;

  typedef enum logic [1:0] {
    W0 = 2'd0,
    W1 = 2'd1,
    W2 = 2'd2,
    W3 = 2'd3
  } widx_t;

  function automatic logic [31:0] pack_w2(input logic we, input logic [4:0] waddr);
    return {we, 26'b0, waddr};
  endfunction
endpackage

// File: rtl/trace_fifo.sv
// Single-clock FIFO; level counter disambiguates full from empty. Storage is never cleared.
module trace_fifo #(
  parameter int unsigned WIDTH = 102,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset && do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/cpu_trace_buffer.sv
// Captures retired-instruction records into a FIFO and streams each as four 32-bit words.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DROP_W = 16
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     cap_valid,
  input  logic [31:0]              pc,
  input  logic [31:0]              inst,
  input  logic                     rf_we,
  input  logic [4:0]               rf_waddr,
  input  logic [31:0]              rf_wdata,
  input  logic                     clr_stat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic                     out_last,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt,
  output logic [$clog2(DEPTH):0]   level
);
  logic [TRACE_REC_W-1:0] rec;
  logic [TRACE_REC_W-1:0] head;
  logic                   full;
  logic                   empty;
  logic                   pop;
  logic                   drop;
  widx_t                  widx;
  widx_t                  widx_nxt;

  assign rec       = {pc, inst, rf_we, rf_waddr, rf_wdata};
  // Fullness is the pre-edge state, so a same-cycle W3 pop cannot rescue a push.
  assign drop      = cap_valid & full;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready & (widx == W3);

  trace_fifo #(
    .WIDTH (TRACE_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_in (clk_in),
    .reset  (reset),
    .push   (cap_valid),
    .pop    (pop),
    .din    (rec),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  always_ff @(posedge clk_in) begin
    if (!reset) widx <= W0;
    else        widx <= widx_nxt;
  end

  always_comb begin
    widx_nxt = widx;
    if (out_valid && out_ready) begin
      case (widx)
        W0:      widx_nxt = W1;
        W1:      widx_nxt = W2;
        W2:      widx_nxt = W3;
        default: widx_nxt = W0;
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    case (widx)
      W0: out_data = head[PC_LSB +: 32];
      W1: out_data = head[INST_LSB +: 32];
      W2: out_data = pack_w2(head[WE_BIT], head[WADDR_LSB +: 5]);
      default: begin
        out_data = head[WDATA_LSB +: 32];
        out_last = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset || clr_stat) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: expected stream words queued at capture, checked by a monitor.
module tb_cpu_trace_buffer;
  logic        clk_in = 1'b0;
  logic        reset;
  logic        cap_valid;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        clr_stat;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic [4:0]  level;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];

  cpu_trace_buffer #(
    .DEPTH  (16),
    .DROP_W (16)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .cap_valid (cap_valid),
    .pc        (pc),
    .inst      (inst),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .clr_stat  (clr_stat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .level     (level)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_rec(input logic [31:0] p, input logic [31:0] i, input logic we,
                          input logic [4:0] wa, input logic [31:0] wd, input bit accept);
    cap_valid = 1'b1;
    pc = p; inst = i; rf_we = we; rf_waddr = wa; rf_wdata = wd;
    if (accept) begin
      exp_q.push_back({1'b0, p});
      exp_q.push_back({1'b0, i});
      exp_q.push_back({1'b0, we, 26'b0, wa});
      exp_q.push_back({1'b1, wd});
    end
    tick();
    cap_valid = 1'b0;
  endtask

  // Monitor: every word the consumer accepts must match the next queued expectation.
  always @(negedge clk_in) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_unexpected: got %h last %b, expected no word", out_data, out_last);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({out_last, out_data} !== e) begin
          errors++;
          $display("FAIL stream_word: got %h last %b, expected %h last %b",
                   out_data, out_last, e[31:0], e[32]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit found;
    reset = 1'b0; cap_valid = 1'b0; pc = '0; inst = '0; rf_we = 1'b0;
    rf_waddr = '0; rf_wdata = '0; clr_stat = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    chk("reset_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_level", {27'b0, level}, 32'd0);
    chk("reset_overflow", {31'b0, overflow}, 32'd0);
    chk("reset_drop_cnt", {16'b0, drop_cnt}, 32'd0);
    reset = 1'b1;
    tick();

    // Single record, consumer always ready
    out_ready = 1'b1;
    push_rec(32'h00400000, 32'h3C010000, 1'b1, 5'd1, 32'h00000000, 1'b1);
    chk("first_latency_valid", {31'b0, out_valid}, 32'd1);
    chk("first_latency_w0", out_data, 32'h00400000);
    repeat (4) tick();
    chk("single_drained_valid", {31'b0, out_valid}, 32'd0);

    // Backpressure during W1
    push_rec(32'h00400004, 32'h3C010000, 1'b0, 5'd9, 32'h12345678, 1'b1);
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_w1_data", out_data, 32'h3C010000);
      chk("stall_w1_last", {31'b0, out_last}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    repeat (4) tick();
    chk("stall_drained_valid", {31'b0, out_valid}, 32'd0);

    // Overflow: 20 back-to-back captures with no consumer
    out_ready = 1'b0;
    for (int r = 0; r < 20; r++)
      push_rec(32'h00001000 + 32'(r * 4), 32'hA0000000 + 32'(r), r[0], 5'(r),
               32'hD0000000 + 32'(r), r < 16);
    chk("ovf_level", {27'b0, level}, 32'd16);
    chk("ovf_drop_cnt", {16'b0, drop_cnt}, 32'd4);
    chk("ovf_flag", {31'b0, overflow}, 32'd1);

    // Capture on the full edge while W3 pops: still dropped
    out_ready = 1'b1;
    repeat (3) tick();
    push_rec(32'hDEAD0000, 32'hDEAD0001, 1'b1, 5'd31, 32'hDEAD0003, 1'b0);
    out_ready = 1'b0;
    chk("fullpop_level", {27'b0, level}, 32'd15);
    chk("fullpop_drop_cnt", {16'b0, drop_cnt}, 32'd5);

    // Refill, then clear coinciding with a drop
    push_rec(32'h0000BEE0, 32'h0000BEE1, 1'b1, 5'd7, 32'h0000BEE3, 1'b1);
    chk("refill_level", {27'b0, level}, 32'd16);
    clr_stat = 1'b1;
    push_rec(32'hBAD00000, 32'hBAD00001, 1'b0, 5'd2, 32'hBAD00003, 1'b0);
    clr_stat = 1'b0;
    chk("clr_drop_cnt", {16'b0, drop_cnt}, 32'd0);
    chk("clr_overflow", {31'b0, overflow}, 32'd0);
    chk("clr_level", {27'b0, level}, 32'd16);
    out_ready = 1'b1;
    repeat (70) tick();
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
    chk("drain_queue", exp_q.size(), 32'd0);

    // Mid-stream reset during W2 of record 3
    push_rec(32'h00002000, 32'h11111111, 1'b1, 5'd1, 32'h0000AAA1, 1'b1);
    push_rec(32'h00002004, 32'h22222222, 1'b1, 5'd2, 32'h0000AAA2, 1'b1);
    push_rec(32'h00002008, 32'h33333333, 1'b1, 5'd3, 32'h0000AAA3, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (out_valid && out_data == 32'h80000003 && level == 5'd1) found = 1'b1;
      else tick();
    end
    chk("rst_reach_w2", {31'b0, found}, 32'd1);
    reset = 1'b0;
    cap_valid = 1'b1;
    pc = 32'hFFFF0000; inst = 32'hFFFF0001; rf_we = 1'b1; rf_waddr = 5'd4; rf_wdata = 32'hFFFF0003;
    tick();
    reset = 1'b1;
    cap_valid = 1'b0;
    exp_q.delete();
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_level", {27'b0, level}, 32'd0);
    push_rec(32'h00003000, 32'h44444444, 1'b0, 5'd5, 32'h0000BBB5, 1'b1);
    chk("post_rst_w0", out_data, 32'h00003000);
    repeat (6) tick();
    chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("final_queue", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
